// File: rtl/ex_operand_fwd_buffer.sv
// EX-stage operand selector with a one-entry operand buffer.
// Resolves rs1/rs2 against NUM_SRC in-flight producers (index 0 has the
// highest priority), applies the PC/immediate selects, holds the
// instruction while the winning producer is still pending (load-use),
// and hands complete operands to the ALU over a valid/ready handshake.
module ex_operand_fwd_buffer #(
   parameter int XLEN    = 32,
   parameter int NUM_SRC = 2,
   parameter int RA_W    = 5,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [RA_W-1:0]           rs1_addr,
   input  logic [RA_W-1:0]           rs2_addr,
   input  logic                      rs1_used,
   input  logic                      rs2_used,
   input  logic [XLEN-1:0]           rs1_data,
   input  logic [XLEN-1:0]           rs2_data,
   input  logic [XLEN-1:0]           pc,
   input  logic [XLEN-1:0]           imm,
   input  logic                      alu_src_a,
   input  logic                      alu_src_b,
   input  logic [NUM_SRC-1:0]        fwd_valid,
   input  logic [NUM_SRC-1:0]        fwd_pending,
   input  logic [NUM_SRC*RA_W-1:0]   fwd_rd,
   input  logic [NUM_SRC*XLEN-1:0]   fwd_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           op_a,
   output logic [XLEN-1:0]           op_b,
   output logic [XLEN-1:0]           store_data,
   output logic                      hazard_stall,
   output logic [CNT_W-1:0]          stall_cnt
);

   typedef enum logic [1:0] {IDLE, RESOLVE, FULL} state_t;

   typedef struct packed {
      logic            ok;
      logic [XLEN-1:0] val;
   } res_t;

   // Resolve one source operand against the forwarding sources. The first
   // (lowest-index) match wins outright: if it is pending the operand stays
   // unresolved even when a lower-priority source has the value ready.
   function automatic res_t resolve_op(
      input logic [RA_W-1:0]         addr,
      input logic                    used,
      input logic [XLEN-1:0]         fallback,
      input logic [NUM_SRC-1:0]      fv,
      input logic [NUM_SRC-1:0]      fp,
      input logic [NUM_SRC*RA_W-1:0] frd,
      input logic [NUM_SRC*XLEN-1:0] fd
   );
      res_t r;
      logic found;
      r.ok  = 1'b1;
      r.val = fallback;
      found = 1'b0;
      if (!used) begin
         r.ok = 1'b1;
      end else if (addr == '0) begin
         r.val = '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && fv[i] && (frd[i*RA_W +: RA_W] == addr)) begin
               found = 1'b1;
               r.ok  = !fp[i];
               r.val = fd[i*XLEN +: XLEN];
            end
         end
      end
      return r;
   endfunction

   state_t            state_q, state_d;

   // Held entry (valid while in RESOLVE)
   logic [RA_W-1:0]   rs1_addr_q, rs2_addr_q;
   logic [XLEN-1:0]   rs1_val_q, rs2_val_q;   // resolved value, or RF data until resolved
   logic              rs1_ok_q, rs2_ok_q;
   logic [XLEN-1:0]   pc_q, imm_q;
   logic              src_a_q, src_b_q;

   logic              accept;
   logic              held;
   logic              all_ok;
   logic              capture;
   res_t              res1, res2;
   logic [XLEN-1:0]   fb1, fb2;
   logic [XLEN-1:0]   cur_pc, cur_imm;
   logic              cur_src_a, cur_src_b;

   assign in_ready = !flush && ((state_q == IDLE) || ((state_q == FULL) && out_ready));
   assign accept   = in_valid && in_ready;
   assign held     = (state_q == RESOLVE);

   // Operand resolution: live inputs on an accept, held entry while in RESOLVE.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      fb1       = held ? rs1_val_q : rs1_data;
      fb2       = held ? rs2_val_q : rs2_data;
      cur_pc    = held ? pc_q      : pc;
      cur_imm   = held ? imm_q     : imm;
      cur_src_a = held ? src_a_q   : alu_src_a;
      cur_src_b = held ? src_b_q   : alu_src_b;
      res1 = resolve_op(held ? rs1_addr_q : rs1_addr, held ? 1'b1 : rs1_used,
                        fb1, fwd_valid, fwd_pending, fwd_rd, fwd_data);
      res2 = resolve_op(held ? rs2_addr_q : rs2_addr, held ? 1'b1 : rs2_used,
                        fb2, fwd_valid, fwd_pending, fwd_rd, fwd_data);
      // Values resolved earlier are latched and never re-evaluated.
      if (held && rs1_ok_q) begin
         res1.ok  = 1'b1;
         res1.val = rs1_val_q;
      end
      if (held && rs2_ok_q) begin
         res2.ok  = 1'b1;
         res2.val = rs2_val_q;
      end
      all_ok = res1.ok && res2.ok;
   end

   // Next-state decode; flush dominates everything except rst.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = all_ok ? FULL : RESOLVE;
            RESOLVE: if (all_ok) state_d = FULL;
            FULL: begin
               if (accept)         state_d = all_ok ? FULL : RESOLVE;
               else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Operands are written only when an entry becomes complete.
   assign capture = (state_d == FULL) && (accept || held);

   // Control state, registered output decodes, output operands and counter.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         out_valid    <= 1'b0;
         hazard_stall <= 1'b0;
         op_a         <= '0;
         op_b         <= '0;
         store_data   <= '0;
         stall_cnt    <= '0;
         rs1_ok_q     <= 1'b0;
         rs2_ok_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_valid    <= (state_d == FULL);
         hazard_stall <= (state_d == RESOLVE);
         if ((state_q == RESOLVE) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush) begin
            rs1_ok_q <= 1'b0;
            rs2_ok_q <= 1'b0;
         end else if (accept || held) begin
            rs1_ok_q <= res1.ok;
            rs2_ok_q <= res2.ok;
         end
         if (capture) begin
            op_a       <= cur_src_a ? cur_pc  : res1.val;
            op_b       <= cur_src_b ? cur_imm : res2.val;
            store_data <= res2.val;
         end
      end
   end

   // Held entry datapath; qualified by the resolved flags, so it needs no reset.
   // NOTE: plain data registers are left unreset on purpose; only the control
   // flags that say whether they hold anything meaningful are reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         rs1_addr_q <= rs1_addr;
         rs2_addr_q <= rs2_addr;
         pc_q       <= pc;
         imm_q      <= imm;
         src_a_q    <= alu_src_a;
         src_b_q    <= alu_src_b;
      end
      if (accept || held) begin
         rs1_val_q <= res1.ok ? res1.val : fb1;
         rs2_val_q <= res2.ok ? res2.val : fb2;
      end
   end

endmodule

// File: tb/tb_ex_operand_fwd_buffer.sv
// Directed bench for ex_operand_fwd_buffer: expected operand triples are
// queued when an instruction is driven and compared when the ALU side
// consumes them; state outputs are checked at fixed points in between.
module tb_ex_operand_fwd_buffer;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        rs1_addr, rs2_addr;
   logic              rs1_used, rs2_used;
   logic [31:0]       rs1_data, rs2_data;
   logic [31:0]       pc, imm;
   logic              alu_src_a, alu_src_b;
   logic [1:0]        fwd_valid, fwd_pending;
   logic [9:0]        fwd_rd;
   logic [63:0]       fwd_data;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       op_a, op_b, store_data;
   logic              hazard_stall;
   logic [15:0]       stall_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] s;
      bit          chk_s;
   } exp_t;
   exp_t sb_q[$];

   ex_operand_fwd_buffer #(.XLEN(32), .NUM_SRC(2), .RA_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_used(rs1_used), .rs2_used(rs2_used),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .pc(pc), .imm(imm), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .op_a(op_a), .op_b(op_b), .store_data(store_data),
      .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input bit chk_s);
      exp_t e;
      e.a = a; e.b = b; e.s = s; e.chk_s = chk_s;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                        input logic u1, input logic u2,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] p, input logic [31:0] im,
                        input logic sa, input logic sb);
      in_valid = 1'b1;
      rs1_addr = a1; rs2_addr = a2; rs1_used = u1; rs2_used = u2;
      rs1_data = d1; rs2_data = d2; pc = p; imm = im;
      alu_src_a = sa; alu_src_b = sb;
   endtask

   task automatic set_src(input int i, input logic v, input logic pd,
                          input logic [4:0] rd, input logic [31:0] d);
      fwd_valid[i]        = v;
      fwd_pending[i]      = pd;
      fwd_rd[i*5 +: 5]    = rd;
      fwd_data[i*32 +: 32] = d;
   endtask

   task automatic clear_src();
      fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
   endtask

   // Consumer side: each handshake pops the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_op_a", op_a, e.a);
            check("sb_op_b", op_b, e.b);
            if (e.chk_s) check("sb_store_data", store_data, e.s);
         end
      end
   end

   // Stimulus sanity: a pending source keeps fwd_valid/fwd_rd stable.
   logic [1:0] prev_pend = '0, prev_valid = '0;
   logic [9:0] prev_rd = '0;
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (prev_pend[i] && fwd_pending[i])
            assert (fwd_valid[i] == prev_valid[i] && fwd_rd[i*5 +: 5] == prev_rd[i*5 +: 5])
               else $error("upstream contract broken on source %0d", i);
      end
      prev_pend  = fwd_pending;
      prev_valid = fwd_valid;
      prev_rd    = fwd_rd;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
      rs1_data = '0; rs2_data = '0; pc = '0; imm = '0;
      alu_src_a = 1'b0; alu_src_b = 1'b0;
      clear_src();
      tick(); tick();

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_hazard", 32'(hazard_stall), 32'd0);
      check("rst_op_a", op_a, 32'd0);
      check("rst_op_b", op_b, 32'd0);
      check("rst_store", store_data, 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // add x3 = x1 + x2, no forwarding
      drive(5'd1, 5'd2, 1, 1, 32'd5, 32'd7, 32'h0, 32'h0, 0, 0);
      #1 check("idle_in_ready", 32'(in_ready), 32'd1);
      push(32'd5, 32'd7, 32'd7, 1);
      tick();
      in_valid = 1'b0;
      check("add_out_valid", 32'(out_valid), 32'd1);
      check("add_op_a", op_a, 32'd5);
      check("add_op_b", op_b, 32'd7);
      check("add_hazard", 32'(hazard_stall), 32'd0);
      tick();
      check("add_drained", 32'(out_valid), 32'd0);

      // Priority: source 0 beats source 1 on the same rd
      drive(5'd4, 5'd0, 1, 1, 32'hAAAA, 32'hBBBB, 32'h0, 32'h0, 0, 0);
      set_src(0, 1, 0, 5'd4, 32'h11);
      set_src(1, 1, 0, 5'd4, 32'h22);
      push(32'h11, 32'h0, 32'h0, 1);
      tick();
      in_valid = 1'b0; clear_src();
      check("prio_op_a", op_a, 32'h11);
      tick();

      // Immediate select on op_b while store_data takes forwarded rs2
      drive(5'd3, 5'd6, 0, 1, 32'h1234, 32'h5555, 32'h100, 32'h40, 1, 1);
      set_src(1, 1, 0, 5'd6, 32'h99);
      push(32'h100, 32'h40, 32'h99, 1);
      tick();
      in_valid = 1'b0; clear_src();
      check("imm_op_b", op_b, 32'h40);
      check("imm_store", store_data, 32'h99);
      tick();

      // Load-use: source 0 pending 3 cycles, source 1 ready with stale value
      drive(5'd5, 5'd0, 1, 1, 32'hCAFE, 32'h0, 32'h0, 32'h0, 0, 0);
      set_src(0, 1, 1, 5'd5, 32'hDEAD);
      set_src(1, 1, 0, 5'd5, 32'h55);
      push(32'h77, 32'h0, 32'h0, 1);
      tick();
      in_valid = 1'b0;
      check("lu_hazard_1", 32'(hazard_stall), 32'd1);
      check("lu_cnt_0", 32'(stall_cnt), 32'd0);
      tick();
      check("lu_hazard_2", 32'(hazard_stall), 32'd1);
      check("lu_cnt_1", 32'(stall_cnt), 32'd1);
      tick();
      check("lu_hazard_3", 32'(hazard_stall), 32'd1);
      check("lu_cnt_2", 32'(stall_cnt), 32'd2);
      check("lu_no_valid", 32'(out_valid), 32'd0);
      set_src(0, 1, 0, 5'd5, 32'h77);
      tick();
      clear_src();
      check("lu_hazard_done", 32'(hazard_stall), 32'd0);
      check("lu_out_valid", 32'(out_valid), 32'd1);
      check("lu_cnt_3", 32'(stall_cnt), 32'd3);
      check("lu_op_a", op_a, 32'h77);
      tick();

      // x0 never forwards; an unused rs2 never stalls
      drive(5'd0, 5'd9, 1, 0, 32'h0, 32'h33, 32'h0, 32'h8, 0, 1);
      set_src(0, 1, 0, 5'd0, 32'hFFFF);
      set_src(1, 1, 1, 5'd9, 32'hBAD);
      push(32'h0, 32'h8, 32'h0, 0);
      tick();
      in_valid = 1'b0; clear_src();
      check("x0_hazard", 32'(hazard_stall), 32'd0);
      check("x0_out_valid", 32'(out_valid), 32'd1);
      check("x0_op_a", op_a, 32'h0);
      tick();

      // Backpressure in FULL, then consume + accept back-to-back
      out_ready = 1'b0;
      drive(5'd1, 5'd2, 1, 1, 32'hA1, 32'hB2, 32'h0, 32'h0, 0, 0);
      push(32'hA1, 32'hB2, 32'hB2, 1);
      tick();
      drive(5'd3, 5'd4, 1, 1, 32'hC3, 32'hD4, 32'h0, 32'h0, 0, 0);
      #1 check("bp_in_ready", 32'(in_ready), 32'd0);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_op_a", op_a, 32'hA1);
         check("bp_op_b", op_b, 32'hB2);
         check("bp_in_ready_hold", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1 check("b2b_in_ready", 32'(in_ready), 32'd1);
      push(32'hC3, 32'hD4, 32'hD4, 1);
      tick();
      in_valid = 1'b0;
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      check("b2b_op_a", op_a, 32'hC3);
      tick();
      check("b2b_drained", 32'(out_valid), 32'd0);

      // Flush while in RESOLVE
      drive(5'd5, 5'd0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      set_src(0, 1, 1, 5'd5, 32'h0);
      tick();
      check("fl_hazard", 32'(hazard_stall), 32'd1);
      flush = 1'b1;
      drive(5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 32'h0, 32'h0, 0, 0);
      #1 check("fl_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0; clear_src();
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_hazard_off", 32'(hazard_stall), 32'd0);
      check("fl_cnt_kept", 32'(stall_cnt >= 16'd3), 32'd1);
      tick();
      check("fl_still_idle", 32'(out_valid), 32'd0);

      // Reset in the middle of RESOLVE
      drive(5'd5, 5'd0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      set_src(0, 1, 1, 5'd5, 32'h0);
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_hazard", 32'(hazard_stall), 32'd0);
      check("mrst_op_a", op_a, 32'd0);
      check("mrst_op_b", op_b, 32'd0);
      check("mrst_store", store_data, 32'd0);
      check("mrst_cnt", 32'(stall_cnt), 32'd0);
      clear_src();
      tick(); tick();
      check("mrst_dropped", 32'(out_valid), 32'd0);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
